// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 core and its boot-time program loader.
package mips_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    RUN,
    DONE,
    ERR
  } loader_state_t;

  localparam logic [5:0] HLT_OP = 6'h3f;
  localparam int         OP_MSB = 31;
  localparam int         OP_LSB = 26;

  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/mips_prog_loader.sv
// Streams a program into the core's unified memory from address 0, keeps the
// core halted during the load, then releases it and waits for HLT.
module mips_prog_loader
  import mips_pkg::*;
#(
  parameter int          ADDR_W = 10,
  parameter logic [5:0]  HLT_OP = mips_pkg::HLT_OP
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              core_start,
  input  logic              core_halted,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       checksum,
  output logic              hlt_seen,
  output logic              err_overflow
);

  loader_state_t state;

  logic handshake;
  logic at_last_addr;

  assign in_ready     = (state == LOAD);
  assign handshake    = in_valid && in_ready;
  assign at_last_addr = (word_count[ADDR_W-1:0] == {ADDR_W{1'b1}});

  // Single FSM block: write register, statistics and core control all
  // registered here. mem_we and core_start default low so each is a pulse.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state        <= IDLE;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      core_hold    <= 1'b1;
      core_start   <= 1'b0;
      done         <= 1'b0;
      word_count   <= '0;
      checksum     <= '0;
      hlt_seen     <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      core_start <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            word_count   <= '0;
            checksum     <= '0;
            hlt_seen     <= 1'b0;
            err_overflow <= 1'b0;
            done         <= 1'b0;
            core_hold    <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          if (handshake) begin
            mem_we     <= 1'b1;
            mem_addr   <= word_count[ADDR_W-1:0];
            mem_wdata  <= in_data;
            word_count <= word_count + (ADDR_W+1)'(1);
            checksum   <= checksum + in_data;
            if (opcode_of(in_data) == HLT_OP) begin
              hlt_seen <= 1'b1;
            end
            if (in_last) begin
              state <= FLUSH;
            end else if (at_last_addr) begin
              err_overflow <= 1'b1;
              state        <= ERR;
            end
          end
        end
        FLUSH: begin
          core_hold  <= 1'b0;
          core_start <= 1'b1;
          state      <= RUN;
        end
        RUN: begin
          // HALTED is stale on the release cycle; only trust it afterwards.
          if (!core_start && core_halted) begin
            done      <= 1'b1;
            core_hold <= 1'b1;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Self-checking bench for mips_prog_loader: a 1K-word instance for normal
// loads and a 3-bit-address instance for the overflow path, sharing stimulus.
`timescale 1ns/1ps
module tb_mips_prog_loader;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        core_halted;

  logic        in_ready_b, mem_we_b, core_hold_b, core_start_b, done_b, hlt_seen_b, err_overflow_b;
  logic [9:0]  mem_addr_b;
  logic [31:0] mem_wdata_b, checksum_b;
  logic [10:0] word_count_b;

  logic        in_ready_s, mem_we_s, core_hold_s, core_start_s, done_s, hlt_seen_s, err_overflow_s;
  logic [2:0]  mem_addr_s;
  logic [31:0] mem_wdata_s, checksum_s;
  logic [3:0]  word_count_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
  } wr_t;

  wr_t         obs_b[$];
  wr_t         obs_s[$];
  logic [31:0] prog[$];

  always #5 clk1 = ~clk1;

  mips_prog_loader #(.ADDR_W(10)) dut_b (
    .clk1(clk1), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .core_hold(core_hold_b), .core_start(core_start_b),
    .core_halted(core_halted), .done(done_b), .word_count(word_count_b),
    .checksum(checksum_b), .hlt_seen(hlt_seen_b), .err_overflow(err_overflow_b)
  );

  mips_prog_loader #(.ADDR_W(3)) dut_s (
    .clk1(clk1), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready_s), .mem_we(mem_we_s), .mem_addr(mem_addr_s),
    .mem_wdata(mem_wdata_s), .core_hold(core_hold_s), .core_start(core_start_s),
    .core_halted(core_halted), .done(done_s), .word_count(word_count_s),
    .checksum(checksum_s), .hlt_seen(hlt_seen_s), .err_overflow(err_overflow_s)
  );

  // Every memory write strobe is logged so address order and idle-cycle
  // silence can be judged after the fact.
  always @(negedge clk1) begin
    if (mem_we_b === 1'b1) obs_b.push_back('{addr: 32'(mem_addr_b), data: mem_wdata_b});
    if (mem_we_s === 1'b1) obs_s.push_back('{addr: 32'(mem_addr_s), data: mem_wdata_s});
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    obs_b.delete();
    obs_s.delete();
  endtask

  task automatic send_word(input logic [31:0] d, input bit last, input bit sel);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 50; i++) begin
      if ((sel ? in_ready_s : in_ready_b) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL handshake_wait: got in_ready=0 expected 1 within 50 cycles");
    end
  endtask

  // Loads prog[] into the large instance and returns on the core_start cycle.
  // gap_mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps.
  task automatic load_and_check(input string name, input int gap_mode);
    logic [31:0] exp_sum = '0;
    bit          exp_hlt = 1'b0;
    bit          bad     = 1'b0;
    int          n       = prog.size();
    start_load();
    for (int i = 0; i < n; i++) begin
      if (gap_mode == 1 && i > 0) tick();
      if (gap_mode == 2) repeat ($urandom_range(0, 2)) tick();
      send_word(prog[i], i == n - 1, 1'b0);
      exp_sum += prog[i];
      if (prog[i][31:26] == 6'h3f) exp_hlt = 1'b1;
    end
    checks++;
    if (core_start_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_flush_quiet: got core_start=%b expected 0", name, core_start_b);
    end
    tick();
    checks++;
    if (core_start_b !== 1'b1 || core_hold_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_start_pulse: got core_start=%b core_hold=%b expected 1 0",
               name, core_start_b, core_hold_b);
    end
    checks++;
    if (word_count_b !== 11'(n)) begin
      errors++;
      $display("[TB] FAIL %s_word_count: got %0d expected %0d", name, word_count_b, n);
    end
    checks++;
    if (checksum_b !== exp_sum) begin
      errors++;
      $display("[TB] FAIL %s_checksum: got %h expected %h", name, checksum_b, exp_sum);
    end
    checks++;
    if (hlt_seen_b !== exp_hlt) begin
      errors++;
      $display("[TB] FAIL %s_hlt_seen: got %b expected %b", name, hlt_seen_b, exp_hlt);
    end
    if (obs_b.size() != n) bad = 1'b1;
    else foreach (obs_b[i]) if (obs_b[i].addr != i || obs_b[i].data !== prog[i]) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL %s_writes: got %0d writes expected %0d in order from address 0",
               name, obs_b.size(), n);
    end
  endtask

  task automatic finish_run(input string name);
    core_halted = 1'b0;
    tick();
    checks++;
    if (core_start_b !== 1'b0 || done_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_run: got core_start=%b done=%b expected 0 0", name, core_start_b, done_b);
    end
    core_halted = 1'b1;
    tick();
    core_halted = 1'b0;
    checks++;
    if (done_b !== 1'b1 || core_hold_b !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_done: got done=%b core_hold=%b expected 1 1", name, done_b, core_hold_b);
    end
  endtask

  task automatic test_reset();
    pulse_reset();
    checks++;
    if ({in_ready_b, mem_we_b, core_hold_b, core_start_b, done_b} !== 5'b00100) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00100",
               {in_ready_b, mem_we_b, core_hold_b, core_start_b, done_b});
    end
    checks++;
    if (mem_addr_b !== '0 || mem_wdata_b !== '0 || word_count_b !== '0 || checksum_b !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: got addr=%h wdata=%h count=%h sum=%h expected all 0",
               mem_addr_b, mem_wdata_b, word_count_b, checksum_b);
    end
    checks++;
    if (hlt_seen_b !== 1'b0 || err_overflow_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got hlt=%b ovf=%b expected 0 0", hlt_seen_b, err_overflow_b);
    end
  endtask

  task automatic set_spec_program();
    prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
             32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
  endtask

  task automatic test_spec_program();
    set_spec_program();
    load_and_check("spec", 0);
    checks++;
    if (checksum_b !== 32'h9B61B037) begin
      errors++;
      $display("[TB] FAIL spec_known_sum: got %h expected 9b61b037", checksum_b);
    end
    finish_run("spec");
  endtask

  task automatic test_toggle_valid();
    set_spec_program();
    load_and_check("toggle", 1);
    finish_run("toggle");
  endtask

  task automatic test_single_word();
    prog = '{32'hfc000000};
    load_and_check("single", 0);
    finish_run("single");
  endtask

  task automatic test_halt_filter();
    set_spec_program();
    load_and_check("filter", 0);
    core_halted = 1'b1;
    tick();
    core_halted = 1'b0;
    checks++;
    if (done_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL filter_early: got done=%b expected 0", done_b);
    end
    repeat (4) tick();
    checks++;
    if (done_b !== 1'b0 || core_hold_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL filter_wait: got done=%b core_hold=%b expected 0 0", done_b, core_hold_b);
    end
    core_halted = 1'b1;
    tick();
    core_halted = 1'b0;
    checks++;
    if (done_b !== 1'b1 || core_hold_b !== 1'b1) begin
      errors++;
      $display("[TB] FAIL filter_done: got done=%b core_hold=%b expected 1 1", done_b, core_hold_b);
    end
  endtask

  task automatic test_random_loads();
    for (int t = 0; t < 6; t++) begin
      int n = $urandom_range(1, 20);
      prog.delete();
      for (int i = 0; i < n; i++) begin
        logic [31:0] w = $urandom;
        if ($urandom_range(0, 7) == 0) w[31:26] = 6'h3f;
        else if (w[31:26] == 6'h3f) w[31:26] = 6'h0a;
        prog.push_back(w);
      end
      load_and_check("random", 2);
      finish_run("random");
    end
  endtask

  task automatic test_overflow();
    pulse_reset();
    start_load();
    for (int i = 0; i < 8; i++) send_word($urandom, 1'b0, 1'b1);
    checks++;
    if (err_overflow_s !== 1'b1 || in_ready_s !== 1'b0 || core_hold_s !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_flag: got ovf=%b in_ready=%b core_hold=%b expected 1 0 1",
               err_overflow_s, in_ready_s, core_hold_s);
    end
    checks++;
    if (word_count_s !== 4'd8) begin
      errors++;
      $display("[TB] FAIL overflow_count: got %0d expected 8", word_count_s);
    end
    tick();
    checks++;
    if (in_ready_s !== 1'b0 || core_start_s !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_hold: got in_ready=%b core_start=%b expected 0 0",
               in_ready_s, core_start_s);
    end
    start_load();
    send_word(32'h12345678, 1'b1, 1'b1);
    tick();
    checks++;
    if (obs_s.size() != 1 || obs_s[0].addr != 0 || err_overflow_s !== 1'b0 || word_count_s !== 4'd1) begin
      errors++;
      $display("[TB] FAIL overflow_reload: got writes=%0d ovf=%b count=%0d expected 1 write at 0, 0, 1",
               obs_s.size(), err_overflow_s, word_count_s);
    end
  endtask

  task automatic test_reset_midload();
    pulse_reset();
    start_load();
    for (int i = 0; i < 4; i++) send_word($urandom, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = $urandom;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (word_count_b !== '0 || checksum_b !== '0 || mem_we_b !== 1'b0 ||
        in_ready_b !== 1'b0 || core_hold_b !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midload_reset: got count=%0d sum=%h we=%b ready=%b hold=%b expected 0 0 0 0 1",
               word_count_b, checksum_b, mem_we_b, in_ready_b, core_hold_b);
    end
    repeat (3) tick();
    checks++;
    if (obs_b.size() != 4) begin
      errors++;
      $display("[TB] FAIL midload_writes: got %0d writes expected 4", obs_b.size());
    end
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    core_halted = 1'b0;
    test_reset();
    test_spec_program();
    test_toggle_valid();
    test_single_word();
    test_halt_filter();
    test_random_loads();
    test_overflow();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
